alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator-side driver for the combinational alu: the execute stage hands it operations, and it drives the alu control and operand inputs.
- Accepts (ctrl, A, B, tag) requests over a valid/ready handshake and buffers them in a small FIFO.
- Presents the FIFO head to the alu, registers the alu result with zero/negative/illegal flags, and returns it over a second valid/ready handshake.
- Decouples the requester from result backpressure.

Parameters:
- DATA_W, 32, operand and result width
- CTRL_W, 4, alu control width
- DEPTH, 4, request FIFO entries (power of two, >=2)
- MAX_OP, 11, highest legal alu control code (0x0..0xB)
- TAG_W, 4, request tag width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at clk edge
- req_ctrl  in  CTRL_W  alu operation code
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B
- req_tag  in  TAG_W  requester tag, returned unchanged
- alu_ctrl  out  CTRL_W  to alu control input
- alu_a  out  DATA_W  to alu A
- alu_b  out  DATA_W  to alu B
- alu_result  in  DATA_W  combinational result from alu
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  registered result
- rsp_tag  out  TAG_W  tag of the response
- rsp_zero  out  1  rsp_result == 0 (legal ops only)
- rsp_neg  out  1  rsp_result[DATA_W-1] (legal ops only)
- rsp_illegal  out  1  req_ctrl was > MAX_OP
- busy  out  1  FIFO non-empty or rsp_valid
- op_count  out  16  responses delivered, wraps 0xFFFF->0x0000

Behaviour:
- Reset (async assert, sync release): FIFO empty; rsp_valid=0; rsp_result=0; rsp_tag=0; all flags 0; op_count=0; busy=0; alu_* = 0.
- req_ready = !fifo_full. No same-cycle pop bypass: a full FIFO holds req_ready low even if a pop happens that cycle.
- Push on req_valid & req_ready. Pointers are log2(DEPTH)+1 bits; full/empty are derived from the wrap bit.
- alu_ctrl/alu_a/alu_b are combinational from the FIFO head when non-empty, else all zero.
- Capture condition: cap = !empty & (!rsp_valid | rsp_ready).
  - On cap: pop head, rsp_valid<=1, rsp_tag<=head tag.
  - Legal op: rsp_result<=alu_result; zero and neg computed from alu_result; illegal<=0.
  - Illegal op (head ctrl > MAX_OP): rsp_result<=0, zero<=0, neg<=0, illegal<=1. The alu is still driven with the head values; its result is ignored.
- If rsp_valid & rsp_ready & !cap: rsp_valid<=0; data outputs hold their last values.
- rsp_valid held with rsp_ready=0: all rsp_* outputs stable, FIFO head not popped.
- op_count increments on each rsp_valid & rsp_ready.
- Latency: request accepted at edge N -> rsp_valid high after edge N+1 (1-cycle minimum). Steady-state throughput is 1 op/clk with rsp_ready held high.
- Simultaneous push and pop with FIFO non-full: both occur and occupancy is unchanged.
- Ordering: responses return strictly in request order.
- reset_n asserted mid-stream: all buffered requests and the pending response are discarded immediately, with no partial output.

Test Plan:
- Reset, then one request ctrl=0x0, A=0x0A, B=0x02, tag=3, with the bench alu model returning 0x0C -> rsp_valid one cycle after acceptance; rsp_result=0x0C, tag=3, zero=0, neg=0, illegal=0; op_count=1.
- Sweep ctrl 0x0..0xB back-to-back with A=0x0A, B=0x02 and rsp_ready=1 -> 12 responses on 12 consecutive cycles, in order, each matching the alu model; op_count=12.
- Hold rsp_ready=0 while pushing 6 requests -> first response is captured; req_ready drops after DEPTH further pushes; raising rsp_ready drains all remaining requests in order with no loss or duplication.
- ctrl=0xC and ctrl=0xF -> rsp_illegal=1, rsp_result=0, zero=0, neg=0; the following legal op is unaffected.
- A=B=0xFFFFFFFF with the alu model returning 0xFFFFFFFE -> neg=1, zero=0; a model returning 0 -> zero=1.
- Assert reset_n mid-burst with 3 entries queued -> rsp_valid=0, busy=0, op_count=0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// Request, alu-drive and response bundle for alu_issue_unit.
// slave is the issue unit's view; master is the execute stage plus the alu.
interface alu_issue_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [CTRL_W-1:0] req_ctrl;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_zero;
  logic              rsp_neg;
  logic              rsp_illegal;

  logic              busy;
  logic [15:0]       op_count;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, req_tag, alu_result, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal,
    input  busy, op_count
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, req_tag, alu_result, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_illegal,
    output busy, op_count
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Buffers alu requests in a FIFO, drives the combinational alu from the head and
// returns registered results with zero/negative/illegal flags in request order.
module alu_issue_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MAX_OP = 11,
  parameter int unsigned TAG_W  = 4
) (
  input logic             clk,
  input logic             reset_n,
  alu_issue_unit_if.slave bus
);
  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam logic [CTRL_W-1:0] MAX_CTRL = CTRL_W'(MAX_OP);
  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W+1)'(1);

  logic [CTRL_W-1:0] r_ctrl_mem [DEPTH];
  logic [DATA_W-1:0] r_a_mem    [DEPTH];
  logic [DATA_W-1:0] r_b_mem    [DEPTH];
  logic [TAG_W-1:0]  r_tag_mem  [DEPTH];

  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_rsp_zero;
  logic              r_rsp_neg;
  logic              r_rsp_illegal;
  logic [15:0]       r_op_count;

  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_cap;
  logic              w_rsp_fire;
  logic              w_illegal;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic [TAG_W-1:0]  w_head_tag;

  assign w_wr_idx    = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx    = r_rd_ptr[PTR_W-1:0];
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);
  assign w_push      = bus.req_valid && !w_full;
  assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;
  // Refill the response slot whenever it is empty or being consumed this cycle.
  assign w_cap       = !w_empty && (!r_rsp_valid || bus.rsp_ready);

  assign w_head_ctrl = r_ctrl_mem[w_rd_idx];
  assign w_head_a    = r_a_mem[w_rd_idx];
  assign w_head_b    = r_b_mem[w_rd_idx];
  assign w_head_tag  = r_tag_mem[w_rd_idx];
  assign w_illegal   = (w_head_ctrl > MAX_CTRL);

  // Payload storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ctrl_mem[w_wr_idx] <= bus.req_ctrl;
      r_a_mem[w_wr_idx]    <= bus.req_a;
      r_b_mem[w_wr_idx]    <= bus.req_b;
      r_tag_mem[w_wr_idx]  <= bus.req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_tag     <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_neg     <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_op_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_cap) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_rsp_valid <= 1'b1;
        r_rsp_tag   <= w_head_tag;
        if (w_illegal) begin
          r_rsp_result  <= '0;
          r_rsp_zero    <= 1'b0;
          r_rsp_neg     <= 1'b0;
          r_rsp_illegal <= 1'b1;
        end else begin
          r_rsp_result  <= bus.alu_result;
          r_rsp_zero    <= (bus.alu_result == '0);
          r_rsp_neg     <= bus.alu_result[DATA_W-1];
          r_rsp_illegal <= 1'b0;
        end
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_rsp_fire) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  always_comb begin
    bus.alu_ctrl = '0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    if (!w_empty) begin
      bus.alu_ctrl = w_head_ctrl;
      bus.alu_a    = w_head_a;
      bus.alu_b    = w_head_b;
    end
  end

  assign bus.req_ready   = !w_full;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_tag     = r_rsp_tag;
  assign bus.rsp_zero    = r_rsp_zero;
  assign bus.rsp_neg     = r_rsp_neg;
  assign bus.rsp_illegal = r_rsp_illegal;
  assign bus.busy        = !w_empty || r_rsp_valid;
  assign bus.op_count    = r_op_count;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: table vectors, directed corner sequences and a random
// phase, all checked against an in-order queue of expected responses.
module tb_alu_issue_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  logic [15:0] exp_cnt  = '0;
  bit          last_push;
  vec_t        drv_exp;
  vec_t        exp_q[$];
  vec_t        tbl[$];

  alu_issue_unit_if #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW)) bus ();

  alu_issue_unit #(
    .DATA_W(DW), .CTRL_W(CW), .DEPTH(4), .MAX_OP(11), .TAG_W(TW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stand-in combinational alu; codes above 0xB return junk that must be masked.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h7: return 32'($signed(a) >>> b[4:0]);
      4'h8: return {31'd0, $signed(a) < $signed(b)};
      4'h9: return {31'd0, a < b};
      4'hA: return ~(a | b);
      4'hB: return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  function automatic vec_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] t);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.tag = t;
    if (int'(c) > 11) begin
      v.res = '0; v.zero = 1'b0; v.neg = 1'b0; v.ill = 1'b1;
    end else begin
      v.res = alu_fn(c, a, b); v.zero = (v.res == 0); v.neg = v.res[31]; v.ill = 1'b0;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] t, input logic [31:0] r, input logic z,
                              input logic n, input logic il);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.tag = t; v.res = r; v.zero = z; v.neg = n; v.ill = il;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_ctrl  = v.ctrl;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_tag   = v.tag;
    drv_exp       = v;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_ctrl  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
  endtask

  // Observe both handshakes mid-cycle, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_push = 1'b0;
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_pops++;
      exp_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got tag 0x%0h, required no response", bus.rsp_tag);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
        check("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
        check("rsp_flags", 64'({bus.rsp_zero, bus.rsp_neg, bus.rsp_illegal}),
              64'({e.zero, e.neg, e.ill}));
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      exp_q.push_back(drv_exp);
      last_push = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc, input string name);
    idle();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < max_cyc && exp_q.size() > 0; c++) tick();
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    idle();
    bus.rsp_ready = 1'b1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    n_pops  = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp[6];
    logic [35:0] snap;
    int sent;

    // ctrl sweep with A=0x0A, B=0x02, then illegal codes and flag corners.
    tbl.push_back(mk(4'h0, 32'h0A, 32'h02, 4'd0,  32'h0000_000C, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h1, 32'h0A, 32'h02, 4'd1,  32'h0000_0008, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h2, 32'h0A, 32'h02, 4'd2,  32'h0000_0002, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h3, 32'h0A, 32'h02, 4'd3,  32'h0000_000A, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h4, 32'h0A, 32'h02, 4'd4,  32'h0000_0008, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h5, 32'h0A, 32'h02, 4'd5,  32'h0000_0028, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h6, 32'h0A, 32'h02, 4'd6,  32'h0000_0002, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h7, 32'h0A, 32'h02, 4'd7,  32'h0000_0002, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h8, 32'h0A, 32'h02, 4'd8,  32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'h9, 32'h0A, 32'h02, 4'd9,  32'h0000_0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'hA, 32'h0A, 32'h02, 4'd10, 32'hFFFF_FFF5, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'hB, 32'h0A, 32'h02, 4'd11, 32'h0000_0002, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'hC, 32'h0A, 32'h02, 4'd12, 32'h0000_0000, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(4'hF, 32'hFFFF_FFFF, 32'h0, 4'd13, 32'h0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(4'h0, 32'h0A, 32'h02, 4'd14, 32'h0000_000C, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'h7, 32'h8000_0000, 32'h4, 4'd2, 32'hF800_0000, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(4'h8, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0));

    // Reset state and single-request latency.
    do_reset();
    check("reset_rsp", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_zero,
                            bus.rsp_neg, bus.rsp_illegal}), 64'(0));
    check("reset_status", 64'({bus.busy, bus.op_count}), 64'(0));
    check("reset_alu", 64'({bus.alu_ctrl, bus.alu_a}) | 64'(bus.alu_b), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(1));
    drive(model(4'h0, 32'h0A, 32'h02, 4'd3));
    tick();
    check("single_push", 64'(last_push), 64'(1));
    check("single_not_yet_valid", 64'(bus.rsp_valid), 64'(0));
    check("single_busy", 64'(bus.busy), 64'(1));
    check("single_alu_head", 64'({bus.alu_ctrl, bus.alu_a}), 64'({4'h0, 32'h0A}));
    idle();
    tick();
    check("single_valid", 64'(bus.rsp_valid), 64'(1));
    check("single_result", 64'(bus.rsp_result), 64'(32'h0C));
    check("single_tag_flags", 64'({bus.rsp_tag, bus.rsp_zero, bus.rsp_neg, bus.rsp_illegal}),
          64'({4'd3, 3'b000}));
    tick();
    check("single_done", 64'({bus.rsp_valid, bus.busy}), 64'(0));
    check("single_op_count", 64'(bus.op_count), 64'(1));

    // Back-to-back sweep: one response per cycle once the pipe fills.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      tick();
      check("sweep_push", 64'(last_push), 64'(1));
      if (i >= 1) check("sweep_pops", 64'(n_pops), 64'(i - 1));
    end
    idle();
    tick();
    check("sweep_pops_11", 64'(n_pops), 64'(11));
    tick();
    check("sweep_pops_12", 64'(n_pops), 64'(12));
    check("sweep_op_count", 64'(bus.op_count), 64'(12));
    check("sweep_idle", 64'({bus.rsp_valid, bus.busy}), 64'(0));

    // Illegal codes and flag corners.
    for (int i = 12; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
    end
    drain(20, "tbl_drain");
    check("tbl_op_count", 64'(bus.op_count), 64'(12 + tbl.size() - 12));

    // Backpressure: first request captured, DEPTH more fill the FIFO.
    do_reset();
    for (int i = 0; i < 6; i++)
      bp[i] = model(4'(i % 12), $urandom, $urandom, 4'(8 + i));
    bus.rsp_ready = 1'b0;
    sent = 0;
    snap = '0;
    for (int c = 0; c < 8; c++) begin
      if (sent < 6) drive(bp[sent]);
      else idle();
      tick();
      if (last_push) sent++;
      if (c == 3) snap = {bus.rsp_result, bus.rsp_tag};
    end
    check("bp_accepted", 64'(sent), 64'(5));
    check("bp_req_ready_low", 64'(bus.req_ready), 64'(0));
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("bp_stable", 64'({bus.rsp_result, bus.rsp_tag}), 64'(snap));
    check("bp_head_tag", 64'(bus.rsp_tag), 64'(bp[0].tag));
    check("bp_no_pops", 64'(n_pops), 64'(0));
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_no_bypass", 64'(bus.req_ready), 64'(0));
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
      if (sent < 6) drive(bp[sent]);
      else idle();
      tick();
      if (last_push) sent++;
    end
    check("bp_all_sent", 64'(sent), 64'(6));
    check("bp_all_back", 64'(exp_q.size()), 64'(0));
    check("bp_op_count", 64'(bus.op_count), 64'(6));

    // Reset mid-burst with three entries queued behind a pending response.
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(model(4'h0, 32'(i), 32'h10, 4'(i)));
      tick();
    end
    idle();
    check("mid_busy_before", 64'({bus.rsp_valid, bus.busy}), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rsp_cleared", 64'({bus.rsp_valid, bus.rsp_result}), 64'(0));
    check("mid_status_cleared", 64'({bus.busy, bus.op_count}), 64'(0));
    check("mid_fifo_cleared", 64'({bus.req_ready, bus.alu_a}), 64'({1'b1, 32'h0}));
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(model(4'h2, 32'h0000_F0F0, 32'h0000_00FF, 4'd5));
    tick();
    drain(10, "mid_after_drain");
    check("mid_after_op_count", 64'(bus.op_count), 64'(1));

    // Random traffic with random backpressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 3))
          0: a = '0;
          1: begin a = '1; b = '1; end
          default: ;
        endcase
        drive(model(4'($urandom_range(0, 15)), a, b, 4'($urandom)));
      end else begin
        idle();
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain(60, "rand_drain");
    check("rand_op_count", 64'(bus.op_count), 64'(exp_cnt));
    check("rand_idle", 64'({bus.rsp_valid, bus.busy}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
